// File: rtl/instruction_fetch.sv
// Instruction fetch stage with IF/ID register. Issues one synchronous memory read per
// advancing cycle and parks returned data in a skid entry whenever the stage cannot advance.
module instruction_fetch #(
    parameter int                           PC_WIDTH          = 20,
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]          RESET_PC          = '0,
    parameter logic [PC_WIDTH-1:0]          PC_INCREMENT      = PC_WIDTH'(1),
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION   = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         inst_rd_en_in,
    input  logic                         general_flush_in,
    input  logic                         decode_flush_in,
    input  logic                         select_new_pc_in,
    input  logic [PC_WIDTH-1:0]          new_pc_in,
    output logic [PC_WIDTH-1:0]          inst_mem_addr_out,
    output logic                         inst_mem_rd_en_out,
    input  logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]          new_pc_out,
    output logic                         valid_out
);

    logic [PC_WIDTH-1:0]          r_pc;
    logic [PC_WIDTH-1:0]          r_fetch_pc;
    logic                         r_fetch_vld;
    logic [INSTRUCTION_WIDTH-1:0] r_skid;
    logic [PC_WIDTH-1:0]          r_skid_pc;
    logic                         r_skid_vld;
    logic [INSTRUCTION_WIDTH-1:0] r_inst;
    logic [PC_WIDTH-1:0]          r_npc;
    logic                         r_vld;

    logic                         w_adv;
    logic                         w_gflush;
    logic                         w_dflush;
    logic                         w_capture;
    logic [INSTRUCTION_WIDTH-1:0] w_load_inst;
    logic [PC_WIDTH-1:0]          w_load_npc;
    logic                         w_load_vld;

    assign w_adv     = en & inst_rd_en_in;
    assign w_gflush  = en & general_flush_in;
    assign w_dflush  = en & decode_flush_in;
    // Read data is only present for one cycle, so any non-advancing cycle must park it.
    assign w_capture = r_fetch_vld & ~w_adv & ~w_gflush;

    assign inst_mem_addr_out  = r_pc;
    assign inst_mem_rd_en_out = w_adv;
    assign instruction_out    = r_inst;
    assign new_pc_out         = r_npc;
    assign valid_out          = r_vld;

    always_comb begin
        w_load_inst = NOP_INSTRUCTION;
        w_load_npc  = '0;
        w_load_vld  = 1'b0;
        if (r_skid_vld) begin
            w_load_inst = r_skid;
            w_load_npc  = r_skid_pc + PC_INCREMENT;
            w_load_vld  = 1'b1;
        end else if (r_fetch_vld) begin
            w_load_inst = inst_mem_data_in;
            w_load_npc  = r_fetch_pc + PC_INCREMENT;
            w_load_vld  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (en) begin
            if (select_new_pc_in) begin
                r_pc <= new_pc_in;
            end else if (w_adv) begin
                r_pc <= r_pc + PC_INCREMENT;
            end
        end
    end

    // A redirect or flush in the issuing cycle makes the returning word unwanted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= '0;
            r_fetch_vld <= 1'b0;
        end else if (w_adv) begin
            r_fetch_pc  <= r_pc;
            r_fetch_vld <= ~general_flush_in & ~select_new_pc_in;
        end else if (w_gflush || w_capture) begin
            r_fetch_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid     <= '0;
            r_skid_pc  <= '0;
            r_skid_vld <= 1'b0;
        end else if (w_gflush) begin
            r_skid_vld <= 1'b0;
        end else if (w_capture) begin
            r_skid     <= inst_mem_data_in;
            r_skid_pc  <= r_fetch_pc;
            r_skid_vld <= 1'b1;
        end else if (w_adv) begin
            r_skid_vld <= 1'b0;
        end
    end

    // Either flush overrides an advance; an advancing word is then simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst <= NOP_INSTRUCTION;
            r_npc  <= '0;
            r_vld  <= 1'b0;
        end else if (w_gflush || w_dflush) begin
            r_inst <= NOP_INSTRUCTION;
            r_npc  <= '0;
            r_vld  <= 1'b0;
        end else if (w_adv) begin
            r_inst <= w_load_inst;
            r_npc  <= w_load_npc;
            r_vld  <= w_load_vld;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: an owed-instruction model checked every cycle,
// plus hand-computed expectations along the scripted scenarios.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, rd, gf, df, sel;
    logic [19:0] npc_in;
    logic [19:0] addr;
    logic        rd_en;
    logic [31:0] mem_q;
    logic [31:0] inst;
    logic [19:0] npc_out;
    logic        vld;

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .en                 (en),
        .inst_rd_en_in      (rd),
        .general_flush_in   (gf),
        .decode_flush_in    (df),
        .select_new_pc_in   (sel),
        .new_pc_in          (npc_in),
        .inst_mem_addr_out  (addr),
        .inst_mem_rd_en_out (rd_en),
        .inst_mem_data_in   (mem_q),
        .instruction_out    (inst),
        .new_pc_out         (npc_out),
        .valid_out          (vld)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [19:0] a);
        return 32'h1000 + {12'h0, a};
    endfunction

    // Synchronous memory; garbage when not strobed so stale data cannot masquerade as valid.
    always @(posedge clk) begin
        if (rd_en) mem_q <= mem_fn(addr);
        else       mem_q <= 32'hDEAD_BEEF;
    end

    // Model: the stage owes decode at most one instruction, identified by its address.
    logic [19:0] m_pc, m_owed_pc, m_npc;
    logic        m_owed, m_vld;
    logic [31:0] m_inst;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 20'h0; m_owed <= 1'b0; m_owed_pc <= 20'h0;
            m_inst <= 32'h0; m_npc <= 20'h0; m_vld <= 1'b0;
        end else begin
            if (en && rd) begin
                m_owed    <= !gf && !sel;
                m_owed_pc <= m_pc;
            end else if (en && gf) begin
                m_owed <= 1'b0;
            end
            if (en && (gf || df)) begin
                m_inst <= 32'h0; m_npc <= 20'h0; m_vld <= 1'b0;
            end else if (en && rd) begin
                m_inst <= m_owed ? mem_fn(m_owed_pc) : 32'h0;
                m_npc  <= m_owed ? m_owed_pc + 20'd1 : 20'h0;
                m_vld  <= m_owed;
            end
            if (en && sel)     m_pc <= npc_in;
            else if (en && rd) m_pc <= m_pc + 20'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model.valid", 32'(vld), 32'(m_vld));
        check("model.inst", inst, m_inst);
        if (m_vld) check("model.new_pc", 32'(npc_out), 32'(m_npc));
        check("model.addr", 32'(addr), 32'(m_pc));
        check("model.rd_en", 32'(rd_en), 32'(en & rd));
    end

    task automatic cyc(input logic e, input logic r, input logic g, input logic d,
                       input logic s, input logic [19:0] p);
        en = e; rd = r; gf = g; df = d; sel = s; npc_in = p;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0);
    endtask

    task automatic expect_if(input string name, input logic [31:0] i,
                             input logic [19:0] p, input logic v);
        check({name, ".valid"}, 32'(vld), 32'(v));
        check({name, ".inst"}, inst, i);
        if (v) check({name, ".new_pc"}, 32'(npc_out), 32'(p));
    endtask

    logic [4:0]  mix [16];
    logic [19:0] mix_pc;

    initial begin
        rst_n = 1'b0;
        en = 1'b1; rd = 1'b1; gf = 1'b0; df = 1'b0; sel = 1'b0; npc_in = 20'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        expect_if("reset", 32'h0, 20'h0, 1'b0);
        check("reset.addr", 32'(addr), 32'h0);

        // Sequential stream from RESET_PC
        adv(); expect_if("seq.e1", 32'h0, 20'h0, 1'b0);
        adv(); expect_if("seq.e2", 32'h1000, 20'h1, 1'b1);
        adv(); expect_if("seq.e3", 32'h1001, 20'h2, 1'b1);
        adv(); expect_if("seq.e4", 32'h1002, 20'h3, 1'b1);
        adv(); adv();
        check("seq.addr6", 32'(addr), 32'h6);

        // Three-cycle stall with address 5 in flight
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
            expect_if("stall.hold", 32'h1004, 20'h5, 1'b1);
            check("stall.rd_en", 32'(rd_en), 32'h0);
            check("stall.addr", 32'(addr), 32'h6);
        end
        adv(); expect_if("stall.rel1", 32'h1005, 20'h6, 1'b1);
        adv(); expect_if("stall.rel2", 32'h1006, 20'h7, 1'b1);

        // Redirect with general flush
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 20'h40);
        expect_if("redir.bubble1", 32'h0, 20'h0, 1'b0);
        adv(); expect_if("redir.bubble2", 32'h0, 20'h0, 1'b0);
        check("redir.addr", 32'(addr), 32'h41);
        adv(); expect_if("redir.target", 32'h1040, 20'h41, 1'b1);

        // One-cycle decode flush
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 20'h0);
        expect_if("dflush.nop", 32'h0, 20'h0, 1'b0);
        adv(); expect_if("dflush.next", 32'h1042, 20'h43, 1'b1);
        check("dflush.addr", 32'(addr), 32'h44);

        // PC wrap at the top of the address space
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 20'hFFFFF);
        expect_if("wrap.last", 32'h1043, 20'h44, 1'b1);
        check("wrap.addr_top", 32'(addr), 32'hFFFFF);
        adv(); expect_if("wrap.killed", 32'h0, 20'h0, 1'b0);
        check("wrap.addr0", 32'(addr), 32'h0);
        adv(); expect_if("wrap.inst", 32'h100FFF, 20'h0, 1'b1);

        // Global enable low: flushes ignored, in-flight word parked
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h0);
        expect_if("en0.hold", 32'h100FFF, 20'h0, 1'b1);
        check("en0.addr", 32'(addr), 32'h1);
        adv(); expect_if("en0.resume", 32'h1000, 20'h1, 1'b1);

        // Asynchronous reset with the skid entry full
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
        rst_n = 1'b0;
        #1;
        expect_if("areset", 32'h0, 20'h0, 1'b0);
        check("areset.addr", 32'(addr), 32'h0);
        en = 1'b1; rd = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        rst_n = 1'b1;
        adv(); expect_if("restart.e1", 32'h0, 20'h0, 1'b0);
        adv(); expect_if("restart.e2", 32'h1000, 20'h1, 1'b1);

        // Mixed control sequence, checked by the model: {en, rd, gf, df, sel}
        mix = '{5'b10000, 5'b10001, 5'b11000, 5'b10010, 5'b11010, 5'b11000,
                5'b10000, 5'b10100, 5'b11000, 5'b11000, 5'b00100, 5'b11000,
                5'b10000, 5'b11010, 5'b11001, 5'b11000};
        mix_pc = 20'h100;
        foreach (mix[k]) begin
            cyc(mix[k][4], mix[k][3], mix[k][2], mix[k][1], mix[k][0], mix_pc);
            mix_pc = mix_pc + 20'h10;
        end
        repeat (3) adv();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
